apb_master_bridge: RTL and testbench

- APB requester driving the team's two memory-backed APB slaves (Slave_1 at slave index 0, a second identical slave at index 1).
- Accepts one command at a time on a valid/ready command port and runs a SETUP→ACCESS APB transfer.
- Decodes the address MSB into one of two Psel lines and returns read data or write completion on a one-cycle response pulse.
- Includes a wait-state timeout and a selectable read-data capture latency to match slaves with registered Prdata.

---
 rtl/apb_master_bridge.sv | 172 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS on one of two
// slaves selected by the address MSB, and reports completion on a one-cycle pulse.
module apb_master_bridge #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 16,
    parameter int RDATA_LAT = 1
) (
    input  logic                   Pclk,
    input  logic                   Preset,
    // Command handshake: a command transfers at a rising edge where
    // cmd_valid && cmd_ready; cmd_* are ignored at every other edge.
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADD_WIDTH-1:0]   cmd_addr,
    input  logic [WIDTH-1:0]       cmd_wdata,
    input  logic [WIDTH/8-1:0]     cmd_strb,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic                   Psel1,
    output logic                   Psel2,
    output logic                   Penable,
    output logic                   Pwrite,
    output logic [ADD_WIDTH-2:0]   Paddr,
    output logic [WIDTH-1:0]       Pwdata,
    output logic [WIDTH/8-1:0]     Pstrb,
    input  logic [WIDTH-1:0]       Prdata1,
    input  logic [WIDTH-1:0]       Prdata2,
    input  logic                   Pready1,
    input  logic                   Pready2,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t               state, state_next;
    logic                 sel_hi, sel_hi_next;
    logic [7:0]           cnt, cnt_next;
    logic                 psel1_next, psel2_next, penable_next, pwrite_next;
    logic [ADD_WIDTH-2:0] paddr_next;
    logic [WIDTH-1:0]     pwdata_next;
    logic [WIDTH/8-1:0]   pstrb_next;
    logic                 rsp_valid_next, rsp_err_next;
    logic [WIDTH-1:0]     rsp_rdata_next;
    logic                 pready_sel;
    logic [WIDTH-1:0]     prdata_sel;

    // Only the addressed slave's ready and data lines are ever looked at.
    assign pready_sel = sel_hi ? Pready2 : Pready1;
    assign prdata_sel = sel_hi ? Prdata2 : Prdata1;
    assign cmd_ready  = (state == IDLE) && !Preset;
    assign fsm_state  = state;

    always_comb begin
        state_next     = state;
        sel_hi_next    = sel_hi;
        cnt_next       = cnt;
        psel1_next     = Psel1;
        psel2_next     = Psel2;
        penable_next   = Penable;
        pwrite_next    = Pwrite;
        paddr_next     = Paddr;
        pwdata_next    = Pwdata;
        pstrb_next     = Pstrb;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = rsp_err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next   = SETUP;
                    sel_hi_next  = cmd_addr[ADD_WIDTH-1];
                    cnt_next     = '0;
                    psel1_next   = !cmd_addr[ADD_WIDTH-1];
                    psel2_next   = cmd_addr[ADD_WIDTH-1];
                    penable_next = 1'b0;
                    pwrite_next  = cmd_write;
                    paddr_next   = cmd_addr[ADD_WIDTH-2:0];
                    pwdata_next  = cmd_write ? cmd_wdata : '0;
                    pstrb_next   = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    psel1_next   = 1'b0;
                    psel2_next   = 1'b0;
                    penable_next = 1'b0;
                    if (Pwrite) begin
                        state_next     = IDLE;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b0;
                        rsp_rdata_next = '0;
                    end else if (RDATA_LAT == 0) begin
                        state_next     = IDLE;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b0;
                        rsp_rdata_next = prdata_sel;
                    end else begin
                        state_next = CAPTURE;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    // This was the last allowed wait cycle: abandon the transfer.
                    cnt_next       = cnt + 8'd1;
                    state_next     = IDLE;
                    psel1_next     = 1'b0;
                    psel2_next     = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            CAPTURE: begin
                // Registered-Prdata slaves present the word one cycle after completion.
                state_next     = IDLE;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_rdata_next = prdata_sel;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state     <= IDLE;
            sel_hi    <= 1'b0;
            cnt       <= '0;
            Psel1     <= 1'b0;
            Psel2     <= 1'b0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            sel_hi    <= sel_hi_next;
            cnt       <= cnt_next;
            Psel1     <= psel1_next;
            Psel2     <= psel2_next;
            Penable   <= penable_next;
            Pwrite    <= pwrite_next;
            Paddr     <= paddr_next;
            Pwdata    <= pwdata_next;
            Pstrb     <= pstrb_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: two behavioural memory slaves with registered
// Prdata and programmable wait states, plus a word-level reference memory.
module tb_apb_master_bridge;

    localparam int AW          = 9;
    localparam int W           = 32;
    localparam int TIMEOUT_P   = 16;
    localparam int RDATA_LAT_P = 1;

    logic          Pclk = 1'b0;
    logic          Preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid, rsp_err;
    logic [W-1:0]  rsp_rdata;
    logic          Psel1, Psel2, Penable, Pwrite;
    logic [AW-2:0] Paddr;
    logic [W-1:0]  Pwdata, Prdata1, Prdata2;
    logic [3:0]    Pstrb;
    logic          Pready1, Pready2;
    logic [1:0]    fsm_state;

    apb_master_bridge #(
        .ADD_WIDTH(AW), .WIDTH(W), .TIMEOUT(TIMEOUT_P), .RDATA_LAT(RDATA_LAT_P)
    ) dut (
        .Pclk(Pclk), .Preset(Preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Psel1(Psel1), .Psel2(Psel2), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pstrb(Pstrb),
        .Prdata1(Prdata1), .Prdata2(Prdata2), .Pready1(Pready1), .Pready2(Pready2),
        .fsm_state(fsm_state)
    );

    always #5 Pclk = ~Pclk;

    // ---------------- behavioural slaves ----------------
    logic [31:0] mem0 [0:255] = '{default: 32'h0};
    logic [31:0] mem1 [0:255] = '{default: 32'h0};
    logic [31:0] prdata1_q = 32'h0;
    logic [31:0] prdata2_q = 32'h0;
    int          acc1 = 0;
    int          acc2 = 0;
    int          wait1 = 0;
    int          wait2 = 0;
    logic        hang1 = 1'b0;
    logic        hang2 = 1'b0;

    // An unselected slave drives ready high so a bridge listening to the wrong line shows up.
    assign Pready1 = Psel1 ? (Penable && (acc1 >= wait1) && !hang1) : 1'b1;
    assign Pready2 = Psel2 ? (Penable && (acc2 >= wait2) && !hang2) : 1'b1;
    assign Prdata1 = prdata1_q;
    assign Prdata2 = prdata2_q;

    always @(posedge Pclk) begin
        if (Psel1 && Penable && Pready1) begin
            if (Pwrite) begin
                for (int b = 0; b < 4; b++)
                    if (Pstrb[b]) mem0[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
            end else begin
                prdata1_q <= mem0[Paddr];
            end
        end
        if (Psel1 && Penable && !Pready1) acc1 <= acc1 + 1;
        else acc1 <= 0;
    end

    always @(posedge Pclk) begin
        if (Psel2 && Penable && Pready2) begin
            if (Pwrite) begin
                for (int b = 0; b < 4; b++)
                    if (Pstrb[b]) mem1[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
            end else begin
                prdata2_q <= mem1[Paddr];
            end
        end
        if (Psel2 && Penable && !Pready2) acc2 <= acc2 + 1;
        else acc2 <= 0;
    end

    int acc_cnt = 0;
    always @(posedge Pclk) if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem [0:511] = '{default: 32'h0};
    logic [W-1:0] exp_q[$];

    int   n_asserts = 0;
    int   n_fails   = 0;
    logic proto_bad = 1'b0;
    logic prev_sel1 = 1'b0, prev_sel2 = 1'b0, prev_en = 1'b0, prev_rsp = 1'b0;
    logic [AW-2:0] prev_addr = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply the APB protocol rules to that cycle.
    task automatic tick();
        @(negedge Pclk);
        if (Psel1 && Psel2) proto_bad = 1'b1;
        if (Penable && !(Psel1 || Psel2)) proto_bad = 1'b1;
        if (Penable && !prev_en &&
            !((prev_sel1 || prev_sel2) && prev_sel1 == Psel1 && prev_sel2 == Psel2))
            proto_bad = 1'b1;
        if (Penable && prev_en &&
            (prev_sel1 != Psel1 || prev_sel2 != Psel2 || prev_addr != Paddr))
            proto_bad = 1'b1;
        if (rsp_valid && prev_rsp) proto_bad = 1'b1;
        prev_sel1 = Psel1;
        prev_sel2 = Psel2;
        prev_en   = Penable;
        prev_rsp  = rsp_valid;
        prev_addr = Paddr;
    endtask

    // Issue one command (caller is at a falling edge) and check its whole transfer.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic hang,
                          input logic keep_valid);
        int          lat, tries, exp_lat;
        logic        exp_err, saw1, saw2, bus_bad;
        logic [31:0] exp_rd, exp_pwdata;
        logic [3:0]  exp_pstrb;

        wait1 = waits; wait2 = waits; hang1 = hang; hang2 = hang;
        exp_err    = hang;
        exp_lat    = hang ? (2 + TIMEOUT_P) : ((wr ? 3 : (RDATA_LAT_P != 0 ? 4 : 3)) + waits);
        exp_rd     = (wr || hang) ? 32'h0 : ref_mem[addr];
        exp_pwdata = wr ? wdata : 32'h0;
        exp_pstrb  = wr ? strb : 4'h0;
        if (wr && !hang) ref_mem[addr] = merge(ref_mem[addr], wdata, strb);
        exp_q.push_back(exp_rd);

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        tries = 0;
        while (!cmd_ready && tries < 50) begin tick(); tries++; end
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge Pclk);
        lat = 0; saw1 = 1'b0; saw2 = 1'b0; bus_bad = 1'b0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                if (!keep_valid) cmd_valid = 1'b0;
                cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
                cmd_wdata = $urandom; cmd_strb = 4'($urandom);
            end
            if (!rsp_valid) begin
                saw1 = saw1 | Psel1;
                saw2 = saw2 | Psel2;
                if ((Psel1 || Psel2) && (Paddr !== addr[AW-2:0] || Pwrite !== wr ||
                    Pwdata !== exp_pwdata || Pstrb !== exp_pstrb))
                    bus_bad = 1'b1;
            end
        end while (!rsp_valid && lat < 40);

        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check("rsp_err", rsp_err, exp_err);
        check("psel1_used", saw1, !addr[AW-1]);
        check("psel2_used", saw2, addr[AW-1]);
        check("bus_fields", bus_bad, 0);
        check("bus_idle_at_rsp", {Psel1, Psel2, Penable}, 0);
        check("apb_protocol", proto_bad, 0);
        proto_bad = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rsp_seen;
        int   acc_before;
        logic wr;
        logic [AW-1:0] a;

        Preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0;
        repeat (3) tick();

        // Reset state
        check("rst_psel", {Psel1, Psel2, Penable, Pwrite}, 0);
        check("rst_paddr", Paddr, 0);
        check("rst_pwdata", Pwdata, 0);
        check("rst_pstrb", Pstrb, 0);
        check("rst_rsp", {rsp_valid, rsp_err}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_cmd_ready_in_reset", cmd_ready, 0);
        Preset = 1'b0;
        #1 check("cmd_ready_after_reset", cmd_ready, 1);
        tick();

        // Write then read on slave 0
        do_cmd(1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h005, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        check("wr_rd_value", rsp_rdata, 32'hDEADBEEF);

        // Slave decode
        do_cmd(1'b1, 9'h003, 32'h0BADF00D, 4'hF, 0, 1'b0, 1'b0);
        do_cmd(1'b1, 9'h103, 32'h1A5A5A5A, 4'hF, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h003, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h103, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        check("slave1_value", rsp_rdata, 32'h1A5A5A5A);

        // Byte strobes, then response hold after the pulse
        do_cmd(1'b1, 9'h020, 32'h11223344, 4'hF, 0, 1'b0, 1'b0);
        do_cmd(1'b1, 9'h020, 32'hAABBCCDD, 4'h5, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h020, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        check("strobe_merge", rsp_rdata, 32'h11BB33DD);
        tick();
        check("rsp_pulse_one_cycle", rsp_valid, 0);
        check("rsp_rdata_held", rsp_rdata, 32'h11BB33DD);

        // Wait states and timeout
        do_cmd(1'b1, 9'h030, 32'hCAFE0001, 4'hF, 3, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h030, 32'h0, 4'h0, 3, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h031, 32'h0, 4'h0, 0, 1'b1, 1'b0);
        do_cmd(1'b1, 9'h131, 32'h77777777, 4'hF, 0, 1'b1, 1'b0);
        do_cmd(1'b0, 9'h131, 32'h0, 4'h0, 0, 1'b0, 1'b0);

        // Reset while the transfer sits in ACCESS
        wait1 = 0; hang1 = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h010; cmd_wdata = 32'h0; cmd_strb = 4'h0;
        @(posedge Pclk);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("access_before_reset", {Psel1, Penable}, 2'b11);
        Preset = 1'b1;
        tick();
        check("reset_drops_bus", {Psel1, Psel2, Penable}, 0);
        check("reset_no_rsp", rsp_valid, 0);
        check("cmd_ready_low_in_reset", cmd_ready, 0);
        Preset = 1'b0;
        #1 check("cmd_ready_after_mid_reset", cmd_ready, 1);
        hang1 = 1'b0;
        rsp_seen = 1'b0;
        repeat (TIMEOUT_P + 4) begin
            tick();
            if (rsp_valid || Psel1 || Psel2) rsp_seen = 1'b1;
        end
        check("quiet_after_reset", rsp_seen, 0);
        proto_bad = 1'b0;
        do_cmd(1'b1, 9'h010, 32'h5EED5EED, 4'hF, 1, 1'b0, 1'b0);
        do_cmd(1'b0, 9'h010, 32'h0, 4'h0, 0, 1'b0, 1'b0);

        // Back-to-back writes with cmd_valid held high
        acc_before = acc_cnt;
        for (int i = 0; i < 4; i++)
            do_cmd(1'b1, AW'(9'h040 + i + (i % 2) * 256), $urandom, 4'hF, 0, 1'b0, i != 3);
        tick();
        check("b2b_accept_count", acc_cnt - acc_before, 4);
        for (int i = 0; i < 4; i++)
            do_cmd(1'b0, AW'(9'h040 + i + (i % 2) * 256), 32'h0, 4'h0, 0, 1'b0, 1'b0);

        // Randomized traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 1) * 256 + $urandom_range(0, 7));
            do_cmd(wr, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 9) == 0, i != 39);
        end
        for (int i = 0; i < 8; i++) begin
            do_cmd(1'b0, AW'(i), 32'h0, 4'h0, 0, 1'b0, 1'b0);
            do_cmd(1'b0, AW'(256 + i), 32'h0, 4'h0, 0, 1'b0, 1'b0);
        end
        tick();
        check("final_protocol", proto_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
